s3g_tx: RTL and testbench
=========================

Name: s3g_tx

Overview:
- S3G response packet framer: reads a payload from a response buffer and emits a framed packet to the UART transmitter, one byte per handshake.
- Frame format: 0xD5, length, payload bytes, CRC8 over the payload. This is the same framing and CRC the packet receiver checks.
- Sits between the command/response logic, which fills the buffer, and the UART TX byte serializer.

Parameters:
- TIMEOUT_CYCLES, 16'd50000: watchdog limit on tx_busy staying high per byte. Used only with S3G_TX_WATCHDOG_EN.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- send  input  1  one-cycle request to transmit a packet
- payload_len  input  8  payload byte count; sampled on an accepted send
- buffer_addr  output  8  response buffer read address
- buffer_data  input  8  buffer read data; valid one clk after buffer_addr (synchronous read)
- tx_data  output  8  byte to UART TX
- tx_start  output  1  one-cycle strobe; tx_data is valid in the same cycle
- tx_busy  input  1  UART TX busy; asserted from the cycle after tx_start until the byte completes
- busy  output  1  high from the accepted send until packet_sent or abort
- packet_sent  output  1  one-cycle pulse after the final CRC byte is accepted by the UART
- tx_error  output  1  one-cycle pulse on watchdog abort; tied 0 without S3G_TX_WATCHDOG_EN

Behaviour:
- Reset (async, any state): state=S_IDLE; busy=0, tx_start=0, tx_data=0, packet_sent=0, tx_error=0, buffer_addr=0. Internal crc=0, len=0, remaining count=0.
- S_IDLE:
  - send=1 -> latch len=payload_len, crc=0, buffer_addr=0, busy=1, go S_HDR.
  - send while busy=1 is ignored (no queueing).
- S_HDR: when tx_busy=0, drive tx_data=0xD5 and pulse tx_start -> S_GAP, next byte = LEN.
- S_GAP:
  - One guard cycle; tx_busy is ignored here because the UART raises it this cycle.
  - Then: next=LEN -> S_LEN; next=DATA -> S_FETCH; next=CRC -> S_CRC; next=DONE -> S_WAIT.
- S_LEN: when tx_busy=0, tx_data=len, tx_start -> S_GAP, next = (len==0) ? CRC : DATA.
- S_FETCH: one cycle for buffer read latency (buffer_addr already stable) -> S_DATA.
- S_DATA:
  - When tx_busy=0: tx_data=buffer_data, tx_start, crc=crc8(buffer_data, crc), buffer_addr+1, remaining-1.
  - -> S_GAP, next = (remaining==1) ? CRC : DATA.
- S_CRC: when tx_busy=0, tx_data=crc, tx_start -> S_GAP, next=DONE.
- S_WAIT: when tx_busy=0, pulse packet_sent, busy=0 -> S_IDLE.
  - The byte has fully left the UART before packet_sent, so a new send can issue back-to-back.
- CRC8:
  - Maxim/iButton: reflected polynomial 0x8C, init 0x00, LSB first, no final xor.
  - Covers payload only; 0xD5 and length are excluded.
- buffer_addr runs 0..len-1. With len=255 the last address is 254; no wrap.
- At most one tx_start per byte. tx_start is never asserted while tx_busy=1 (outside S_GAP).
- Mid-packet reset: tx_start drops immediately. No further bytes are sent, and no packet_sent pulse.

Optional Feature:
- Macro: S3G_TX_WATCHDOG_EN.
- With the macro:
  - A 16-bit counter clears on each tx_start and increments while tx_busy=1 in any non-idle state.
  - On reaching TIMEOUT_CYCLES: pulse tx_error, busy=0, state=S_IDLE, no packet_sent.
- Without the macro: no counter; tx_error is constant 0; the block waits on tx_busy indefinitely.

Test Plan:
- len=0, send, UART model busy 10 cycles per byte -> bytes D5 00 00; packet_sent once after the 3rd byte completes; busy drops with it.
- len=1, buffer[0]=0x01 -> bytes D5 01 01 5E; buffer_addr shows 0 only.
- len=4, buffer={0x0A,0x00,0xFF,0x55} -> D5 04 0A 00 FF 55 then CRC equal to the reference-model crc8 of those 4 bytes; matches the receiver's check when looped back into it (packet_done=1, packet_error=0).
- send pulsed again mid-packet, plus tx_busy stretched to 200 cycles on the 2nd byte -> no extra packet; no tx_start while tx_busy=1; stream unchanged.
- Assert rst during the payload of a len=8 packet -> tx_start and busy are 0 asynchronously; no packet_sent; a fresh send then produces a complete correct frame.
- With S3G_TX_WATCHDOG_EN, TIMEOUT_CYCLES=100, tx_busy stuck high after the header -> tx_error pulse about 100 cycles after that tx_start; busy=0; no packet_sent.

Source files
------------

// File: rtl/s3g_tx.sv
// S3G response packet framer: emits 0xD5, length, payload, CRC8 (Maxim) to a UART TX, one byte per handshake.
// Optional watchdog on a stuck tx_busy is compiled in with `define S3G_TX_WATCHDOG_EN.
module s3g_tx #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] payload_len,
  output logic [7:0] buffer_addr,
  input  logic [7:0] buffer_data,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       busy,
  output logic       packet_sent,
  output logic       tx_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_GAP, S_LEN, S_FETCH, S_DATA, S_CRC, S_WAIT
  } state_t;

  typedef enum logic [1:0] {
    N_LEN, N_DATA, N_CRC, N_DONE
  } next_t;

  localparam logic [7:0] SYNC_BYTE = 8'hD5;

  state_t     state;
  next_t      nxt;
  logic [7:0] len;
  logic [7:0] remaining;
  logic [7:0] crc;

`ifdef S3G_TX_WATCHDOG_EN
  logic [15:0] wd_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign tx_error = 1'b0;
`endif

  // Reflected poly 0x8C, LSB first: one payload byte folded into the running CRC.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic [7:0] d);
    logic [7:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 8'h8C;
      else             c = c >> 1;
    end
    return c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      nxt         <= N_LEN;
      len         <= 8'd0;
      remaining   <= 8'd0;
      crc         <= 8'd0;
      buffer_addr <= 8'd0;
      tx_data     <= 8'd0;
      tx_start    <= 1'b0;
      busy        <= 1'b0;
      packet_sent <= 1'b0;
`ifdef S3G_TX_WATCHDOG_EN
      tx_error    <= 1'b0;
      wd_cnt      <= 16'd0;
`endif
    end else begin
      tx_start    <= 1'b0;
      packet_sent <= 1'b0;
`ifdef S3G_TX_WATCHDOG_EN
      tx_error    <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (send) begin
            len         <= payload_len;
            remaining   <= payload_len;
            crc         <= 8'd0;
            buffer_addr <= 8'd0;
            busy        <= 1'b1;
            state       <= S_HDR;
          end
        end
        S_HDR: begin
          if (!tx_busy) begin
            tx_data  <= SYNC_BYTE;
            tx_start <= 1'b1;
            nxt      <= N_LEN;
            state    <= S_GAP;
          end
        end
        S_GAP: begin
          // The UART raises tx_busy during this cycle, so it is not sampled here.
          case (nxt)
            N_LEN:   state <= S_LEN;
            N_DATA:  state <= S_FETCH;
            N_CRC:   state <= S_CRC;
            default: state <= S_WAIT;
          endcase
        end
        S_LEN: begin
          if (!tx_busy) begin
            tx_data  <= len;
            tx_start <= 1'b1;
            nxt      <= (len == 8'd0) ? N_CRC : N_DATA;
            state    <= S_GAP;
          end
        end
        S_FETCH: state <= S_DATA;
        S_DATA: begin
          if (!tx_busy) begin
            tx_data   <= buffer_data;
            tx_start  <= 1'b1;
            crc       <= crc8_step(crc, buffer_data);
            remaining <= remaining - 8'd1;
            state     <= S_GAP;
            // Address stops on the last payload byte so it never leaves 0..len-1.
            if (remaining == 8'd1) begin
              nxt <= N_CRC;
            end else begin
              nxt         <= N_DATA;
              buffer_addr <= buffer_addr + 8'd1;
            end
          end
        end
        S_CRC: begin
          if (!tx_busy) begin
            tx_data  <= crc;
            tx_start <= 1'b1;
            nxt      <= N_DONE;
            state    <= S_GAP;
          end
        end
        S_WAIT: begin
          if (!tx_busy) begin
            packet_sent <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
`ifdef S3G_TX_WATCHDOG_EN
      // Abort overrides the case above; it only fires while tx_busy holds, so no tx_start can collide.
      if (state == S_IDLE) begin
        wd_cnt <= 16'd0;
      end else if (tx_start) begin
        wd_cnt <= 16'd0;
      end else if (tx_busy) begin
        if (wd_cnt >= TIMEOUT_CYCLES - 16'd1) begin
          wd_cnt   <= 16'd0;
          tx_error <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end else begin
          wd_cnt <= wd_cnt + 16'd1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_s3g_tx.sv
// Directed bench for s3g_tx: UART TX model with configurable busy time, synchronous-read buffer model,
// byte-stream monitor. Watchdog case runs only when S3G_TX_WATCHDOG_EN is defined.
module tb_s3g_tx;

  logic       clk;
  logic       rst;
  logic       send;
  logic [7:0] payload_len;
  logic [7:0] buffer_addr;
  logic [7:0] buffer_data;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       busy;
  logic       packet_sent;
  logic       tx_error;

  s3g_tx #(.TIMEOUT_CYCLES(16'd100)) dut (
    .clk(clk), .rst(rst), .send(send), .payload_len(payload_len),
    .buffer_addr(buffer_addr), .buffer_data(buffer_data),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .busy(busy), .packet_sent(packet_sent), .tx_error(tx_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] mem [256];
  always @(posedge clk) buffer_data <= mem[buffer_addr];

  // UART model: busy for busy_len cycles after each tx_start; byte number stretch_at gets stretch_len.
  int  busy_len   = 10;
  int  stretch_at = -1;
  int  stretch_len = 0;
  bit  stuck = 1'b0;
  int  ucnt;
  logic [7:0] got[$];

  always @(posedge clk or posedge rst) begin
    if (rst) ucnt <= 0;
    else if (tx_start) ucnt <= (got.size() == stretch_at) ? stretch_len : busy_len;
    else if (ucnt > 0) ucnt <= ucnt - 1;
  end
  assign tx_busy = (ucnt != 0) || stuck;

  // Monitor, sampled on the falling edge.
  bit clr = 1'b0;
  int sent_cnt = 0, err_cnt = 0, viol = 0, cyc = 0, start_cyc = 0, err_cyc = 0;
  int max_addr = 0;
  logic busy_at_sent = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (clr) begin
      got.delete();
      max_addr = 0;
    end else begin
      if (tx_start) begin
        got.push_back(tx_data);
        start_cyc = cyc;
        if (tx_busy) viol++;
      end
      if (busy && int'(buffer_addr) > max_addr) max_addr = int'(buffer_addr);
    end
    if (packet_sent) begin
      sent_cnt++;
      busy_at_sent = busy;
    end
    if (tx_error) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_cmp++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got_v, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] crc8_ref(input int n);
    logic [7:0] c;
    logic [7:0] d;
    c = 8'h00;
    for (int k = 0; k < n; k++) begin
      d = mem[k];
      for (int b = 0; b < 8; b++) begin
        if ((c[0] ^ d[0]) == 1'b1) c = (c >> 1) ^ 8'h8C;
        else                       c = c >> 1;
        d = d >> 1;
      end
    end
    return c;
  endfunction

  // Sends one packet, optionally re-pulsing send extra_at cycles in, and checks the whole frame.
  task automatic run_packet(input string tag, input int len, input int extra_at);
    int base;
    bit done;
    logic [7:0] crc;
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    base = sent_cnt;
    payload_len = len[7:0];
    send = 1'b1;
    step(1);
    send = 1'b0;
    payload_len = 8'hAA;
    done = 1'b0;
    for (int i = 0; i < 20000 && !done; i++) begin
      if (i == extra_at) send = 1'b1;
      step(1);
      send = 1'b0;
      if (sent_cnt != base) done = 1'b1;
    end
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    step(30);
    check_eq({tag, "_sent_once"}, sent_cnt - base, 32'd1);
    check_eq({tag, "_busy_with_sent"}, 32'(busy_at_sent), 32'd0);
    check_eq({tag, "_nbytes"}, got.size(), len + 3);
    if (got.size() == len + 3) begin
      crc = crc8_ref(len);
      check_eq({tag, "_sync"}, 32'(got[0]), 32'hD5);
      check_eq({tag, "_len"}, 32'(got[1]), len);
      for (int k = 0; k < len; k++)
        check_eq($sformatf("%s_pay%0d", tag, k), 32'(got[k + 2]), 32'(mem[k]));
      check_eq({tag, "_crc"}, 32'(got[len + 2]), 32'(crc));
    end
  endtask

  initial begin
    int base;
    int nb;
    bit hit;
    rst = 1'b1;
    send = 1'b0;
    payload_len = 8'd0;
    for (int k = 0; k < 256; k++) mem[k] = 8'(k * 7 + 3);
    #22;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_tx_start", 32'(tx_start), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_packet_sent", 32'(packet_sent), 32'd0);
    check_eq("rst_tx_error", 32'(tx_error), 32'd0);
    check_eq("rst_buffer_addr", 32'(buffer_addr), 32'd0);
    step(2);
    rst = 1'b0;
    step(3);

    // Empty payload: D5 00 00.
    run_packet("len0", 0, -1);
    if (got.size() == 3) check_eq("len0_crc_const", 32'(got[2]), 32'h00);

    // One byte 0x01 gives CRC 0x5E; address never leaves 0.
    mem[0] = 8'h01;
    run_packet("len1", 1, -1);
    if (got.size() == 4) check_eq("len1_crc_const", 32'(got[3]), 32'h5E);
    check_eq("len1_max_addr", max_addr, 32'd0);

    mem[0] = 8'h0A; mem[1] = 8'h00; mem[2] = 8'hFF; mem[3] = 8'h55;
    run_packet("len4", 4, -1);
    check_eq("len4_max_addr", max_addr, 32'd3);

    // Second byte held busy 200 cycles and a repeated send mid-packet: stream unchanged.
    stretch_at = 2;
    stretch_len = 200;
    run_packet("stretch", 4, 60);
    stretch_at = -1;

    // Reset while a payload byte is being launched.
    for (int k = 0; k < 8; k++) mem[k] = 8'h30 + 8'(k);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    base = sent_cnt;
    payload_len = 8'd8;
    send = 1'b1;
    step(1);
    send = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      step(1);
      if (tx_start && got.size() >= 3) hit = 1'b1;
    end
    check_eq("midrst_reached_payload", 32'(hit), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("midrst_tx_start", 32'(tx_start), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_addr", 32'(buffer_addr), 32'd0);
    nb = got.size();
    step(3);
    rst = 1'b0;
    step(60);
    check_eq("midrst_no_sent", sent_cnt - base, 32'd0);
    check_eq("midrst_no_more_bytes", got.size(), nb);
    run_packet("fresh8", 8, -1);

    // Longest payload: last address is 254.
    busy_len = 3;
    for (int k = 0; k < 255; k++) mem[k] = 8'(k ^ 8'h5A);
    run_packet("len255", 255, -1);
    check_eq("len255_max_addr", max_addr, 32'd254);
    busy_len = 10;

`ifdef S3G_TX_WATCHDOG_EN
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    base = sent_cnt;
    nb = err_cnt;
    payload_len = 8'd2;
    send = 1'b1;
    step(1);
    send = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      step(1);
      if (got.size() >= 1) hit = 1'b1;
    end
    stuck = 1'b1;
    check_eq("wd_hdr_seen", 32'(hit), 32'd1);
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      step(1);
      if (err_cnt != nb) hit = 1'b1;
    end
    check_eq("wd_error_pulse", 32'(hit), 32'd1);
    check_eq("wd_window", 32'((err_cyc - start_cyc >= 95) && (err_cyc - start_cyc <= 110)), 32'd1);
    check_eq("wd_busy", 32'(busy), 32'd0);
    step(5);
    check_eq("wd_single_pulse", err_cnt - nb, 32'd1);
    check_eq("wd_no_sent", sent_cnt - base, 32'd0);
    stuck = 1'b0;
    step(20);
`else
    check_eq("no_tx_error", err_cnt, 32'd0);
`endif

    check_eq("start_while_busy", viol, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
